// File: rtl/rpc_config_path_pkg.sv
// Shared configuration for the RPC DRAM command path: geometry constants,
// the decoded DRAM address struct and the segment-length helper.
package rpc_config_path_pkg;

    localparam int RPC_WORD_BYTES_LOG2 = 5;
    localparam int RPC_COL_WIDTH       = 6;
    localparam int RPC_BANK_WIDTH      = 2;
    localparam int RPC_ROW_WIDTH       = 13;
    localparam int RPC_LEN_WIDTH       = 8;
    localparam int RPC_MAX_BURST       = 64;
    localparam int RPC_BURST_LEN_W     = $clog2(RPC_MAX_BURST);
    localparam int RPC_WADDR_W         = RPC_COL_WIDTH + RPC_BANK_WIDTH + RPC_ROW_WIDTH;
    // Remaining-words counter must hold len+1, i.e. up to 2**LEN_WIDTH.
    localparam int RPC_REM_W           = RPC_LEN_WIDTH + 1;

    typedef logic [RPC_REM_W-1:0] rpc_rem_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } rpc_split_state_e;

    typedef struct packed {
        logic [RPC_ROW_WIDTH-1:0]  row;
        logic [RPC_BANK_WIDTH-1:0] bank;
        logic [RPC_COL_WIDTH-1:0]  col;
    } rpc_dram_addr_t;

    // Words that can go out in one burst starting at col: bounded by the
    // remaining length, the end of the row and the next MAX_BURST boundary.
    function automatic rpc_rem_t rpc_seg_len(input logic [RPC_COL_WIDTH-1:0] col,
                                             input rpc_rem_t rem);
        logic [RPC_COL_WIDTH:0]   room_row;
        logic [RPC_COL_WIDTH:0]   room_burst;
        logic [RPC_COL_WIDTH:0]   room;
        logic [RPC_COL_WIDTH-1:0] burst_mask;
        rpc_rem_t                 room_ext;
        burst_mask = RPC_COL_WIDTH'(RPC_MAX_BURST - 1);
        room_row   = (RPC_COL_WIDTH+1)'(1 << RPC_COL_WIDTH) - {1'b0, col};
        room_burst = (RPC_COL_WIDTH+1)'(RPC_MAX_BURST) - {1'b0, col & burst_mask};
        room       = (room_burst < room_row) ? room_burst : room_row;
        room_ext   = RPC_REM_W'(room);
        return (rem < room_ext) ? rem : room_ext;
    endfunction

endpackage

// File: rtl/rpc_addr_decode.sv
// Word address to {row, bank, col}. Column bits are lowest, so a row
// crossing advances the bank first, then the row. Shared with the PHY side.
module rpc_addr_decode
    import rpc_config_path_pkg::*;
(
    input  logic [RPC_WADDR_W-1:0] waddr_i,
    output rpc_dram_addr_t         dram_o
);

    // Pure bit-field split of the word address.
    always_comb begin
        dram_o.col  = waddr_i[RPC_COL_WIDTH-1:0];
        dram_o.bank = waddr_i[RPC_COL_WIDTH +: RPC_BANK_WIDTH];
        dram_o.row  = waddr_i[RPC_COL_WIDTH+RPC_BANK_WIDTH +: RPC_ROW_WIDTH];
    end

endmodule

// File: rtl/rpc_axi_cmd_splitter.sv
// Splits word-granular upstream bursts into RPC DRAM bursts that stay inside
// one row and never exceed MAX_BURST words. One request in flight at a time.
// Optional statistics counters are built when RPC_SPLIT_STATS_EN is defined.
module rpc_axi_cmd_splitter
    import rpc_config_path_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int WORD_BYTES_LOG2 = RPC_WORD_BYTES_LOG2,
    parameter int COL_WIDTH       = RPC_COL_WIDTH,
    parameter int BANK_WIDTH      = RPC_BANK_WIDTH,
    parameter int ROW_WIDTH       = RPC_ROW_WIDTH,
    parameter int LEN_WIDTH       = RPC_LEN_WIDTH,
    parameter int MAX_BURST       = RPC_MAX_BURST,
    parameter int ID_WIDTH        = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [ADDR_WIDTH-1:0]        req_addr_i,
    input  logic [LEN_WIDTH-1:0]         req_len_i,
    input  logic                         req_write_i,
    input  logic [ID_WIDTH-1:0]          req_id_i,
    output logic                         cmd_valid_o,
    input  logic                         cmd_ready_i,
    output logic [BANK_WIDTH-1:0]        cmd_bank_o,
    output logic [ROW_WIDTH-1:0]         cmd_row_o,
    output logic [COL_WIDTH-1:0]         cmd_col_o,
    output logic [$clog2(MAX_BURST)-1:0] cmd_len_o,
    output logic                         cmd_write_o,
    output logic [ID_WIDTH-1:0]          cmd_id_o,
    output logic                         cmd_last_o,
    output logic                         busy_o,
    output logic [31:0]                  stat_seg_cnt_o,
    output logic [31:0]                  stat_split_cnt_o
);

    localparam int WADDR_W   = COL_WIDTH + BANK_WIDTH + ROW_WIDTH;
    localparam int CMD_LEN_W = $clog2(MAX_BURST);

    rpc_split_state_e      state_q, state_d;
    logic [WADDR_W-1:0]    waddr_q, waddr_d;
    rpc_rem_t              rem_q, rem_d;
    logic                  write_q, write_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;

    logic [WADDR_W-1:0]    req_waddr;
    rpc_rem_t              req_rem;
    rpc_dram_addr_t        cur_addr;
    rpc_rem_t              seg;
    logic                  seg_last;
    logic                  split;
    logic                  unused_addr_bits;

    // Byte offset and address bits above the DRAM map are don't-care.
    assign req_waddr        = req_addr_i[WORD_BYTES_LOG2 +: WADDR_W];
    assign unused_addr_bits = ^{req_addr_i[WORD_BYTES_LOG2-1:0],
                                req_addr_i[ADDR_WIDTH-1:WORD_BYTES_LOG2+WADDR_W]};
    assign req_rem          = RPC_REM_W'(req_len_i) + RPC_REM_W'(1);

    rpc_addr_decode u_addr_decode (
        .waddr_i (waddr_q),
        .dram_o  (cur_addr)
    );

    // Current segment size is a pure function of the latched pointer, so the
    // cmd_* outputs stay frozen while the downstream side stalls.
    assign seg      = rpc_seg_len(cur_addr.col, rem_q);
    assign seg_last = (seg == rem_q);
    assign split    = (state_q == ST_SPLIT);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Request context: word pointer, words remaining, direction and ID.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            waddr_q <= '0;
            rem_q   <= '0;
            write_q <= 1'b0;
            id_q    <= '0;
        end else begin
            waddr_q <= waddr_d;
            rem_q   <= rem_d;
            write_q <= write_d;
            id_q    <= id_d;
        end
    end

    // Next state: latch on accept, advance pointer on each cmd handshake.
    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        rem_d   = rem_q;
        write_d = write_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    waddr_d = req_waddr;
                    rem_d   = req_rem;
                    write_d = req_write_i;
                    id_d    = req_id_i;
                    state_d = ST_SPLIT;
                end
            end
            ST_SPLIT: begin
                if (cmd_ready_i) begin
                    // Pointer wraps at top of memory back to bank 0 / row 0.
                    waddr_d = waddr_q + WADDR_W'(seg);
                    rem_d   = rem_q - seg;
                    if (seg_last) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: data fields read as zero whenever no segment is offered.
    always_comb begin
        req_ready_o = ~split;
        cmd_valid_o = split;
        busy_o      = split;
        cmd_bank_o  = '0;
        cmd_row_o   = '0;
        cmd_col_o   = '0;
        cmd_len_o   = '0;
        cmd_write_o = 1'b0;
        cmd_id_o    = '0;
        cmd_last_o  = 1'b0;
        if (split) begin
            cmd_bank_o  = cur_addr.bank;
            cmd_row_o   = cur_addr.row;
            cmd_col_o   = cur_addr.col;
            cmd_len_o   = CMD_LEN_W'(seg - RPC_REM_W'(1));
            cmd_write_o = write_q;
            cmd_id_o    = id_q;
            cmd_last_o  = seg_last;
        end
    end

`ifdef RPC_SPLIT_STATS_EN
    logic [31:0] stat_seg_cnt_q, stat_seg_cnt_d;
    logic [31:0] stat_split_cnt_q, stat_split_cnt_d;
    logic        req_multi;

    // Request needs several bursts when its first segment is shorter than it.
    assign req_multi = (rpc_seg_len(req_waddr[COL_WIDTH-1:0], req_rem) != req_rem);

    // Saturating event counters.
    always_comb begin
        stat_seg_cnt_d   = stat_seg_cnt_q;
        stat_split_cnt_d = stat_split_cnt_q;
        if (split && cmd_ready_i && (stat_seg_cnt_q != '1))
            stat_seg_cnt_d = stat_seg_cnt_q + 32'd1;
        if (!split && req_valid_i && req_multi && (stat_split_cnt_q != '1))
            stat_split_cnt_d = stat_split_cnt_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_seg_cnt_q   <= '0;
            stat_split_cnt_q <= '0;
        end else begin
            stat_seg_cnt_q   <= stat_seg_cnt_d;
            stat_split_cnt_q <= stat_split_cnt_d;
        end
    end

    assign stat_seg_cnt_o   = stat_seg_cnt_q;
    assign stat_split_cnt_o = stat_split_cnt_q;
`else
    assign stat_seg_cnt_o   = '0;
    assign stat_split_cnt_o = '0;
`endif

endmodule
